// File: rtl/radix16_booth_pkg.sv
// Shared constants and FSM encoding for the radix-16 Booth multiplier core.
package radix16_booth_pkg;

  localparam int unsigned DIGITS   = 8;
  localparam logic [3:0]  CNT_IDLE = 4'd8;
  localparam int unsigned PP_W     = 36;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/radix16_booth_mult_if.sv
// Issue/writeback handshake plus the external radix selector path of the Booth multiplier.
interface radix16_booth_mult_if;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel_count;
  logic [32:0] sel_b;
  logic        sel_sign;
  logic [3:0]  sel_mag;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, a, b, sel_sign, sel_mag,
    input  sel_count, sel_b, busy, done, product
  );

  modport slave (
    input  start, a, b, sel_sign, sel_mag,
    output sel_count, sel_b, busy, done, product
  );

endinterface

// File: rtl/booth_pp_gen.sv
// Partial product generator: +/- mag*A for a Booth digit magnitude 0..8, sign-extended to 36 bits.
module booth_pp_gen
  import radix16_booth_pkg::*;
(
  input  logic [31:0]     a,
  input  logic [3:0]      mag,
  input  logic            sign,
  output logic [PP_W-1:0] pp
);

  logic [PP_W-1:0] a1, a2, a3, a4, a5, a7, a8;
  logic [PP_W-1:0] mult;

  assign a1 = {{(PP_W-32){a[31]}}, a};
  assign a2 = a1 << 1;
  assign a4 = a1 << 2;
  assign a8 = a1 << 3;
  assign a3 = a2 + a1;
  assign a5 = a4 + a1;
  assign a7 = a8 - a1;

  always_comb begin
    mult = '0;
    case (mag)
      4'd1:    mult = a1;
      4'd2:    mult = a2;
      4'd3:    mult = a3;
      4'd4:    mult = a4;
      4'd5:    mult = a5;
      4'd6:    mult = a3 << 1;
      4'd7:    mult = a7;
      4'd8:    mult = a8;
      default: mult = '0;  // out-of-range magnitudes contribute nothing
    endcase
    // Negating zero yields zero, so a signed zero digit adds nothing.
    pp = sign ? -mult : mult;
  end

endmodule

// File: rtl/radix16_booth_mult.sv
// Iterative signed 32x32->64 radix-16 Booth multiplier; one digit accumulated per RUN cycle.
// Define RADIX16_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module radix16_booth_mult
  import radix16_booth_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned Digits = DIGITS
) (
  input  logic                 clk,
  input  logic                 reset,
  radix16_booth_mult_if.slave  bus
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [Width-1:0]  a_q, a_d, b_q, b_d;
  logic [63:0]       acc_q, acc_d, prod_q, prod_d;
  logic [PP_W-1:0]   pp;
  logic [63:0]       pp_shifted;
  logic              last_digit;

  booth_pp_gen u_pp_gen (
    .a    (a_q),
    .mag  (bus.sel_mag),
    .sign (bus.sel_sign),
    .pp   (pp)
  );

  assign pp_shifted = {{(64-PP_W){pp[PP_W-1]}}, pp} << {cnt_q, 2'b00};

`ifdef RADIX16_EARLY_TERM_EN
  // Uniform bits above the current window mean every remaining digit recodes to zero.
  logic [32:0] upper;
  assign upper      = $signed(bus.sel_b) >>> {cnt_q + 4'd1, 2'b00};
  assign last_digit = (cnt_q == 4'(Digits - 1)) || (upper == '0) || (upper == '1);
`else
  assign last_digit = (cnt_q == 4'(Digits - 1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        acc_d = acc_q + pp_shifted;
        cnt_d = cnt_q + 4'd1;
        if (last_digit) begin
          state_d = StDone;
          prod_d  = acc_d;  // product is valid in the same cycle done is raised
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.sel_count = (state_q == StRun) ? cnt_q : CNT_IDLE;
  assign bus.sel_b     = {b_q, 1'b0};
  assign bus.product   = prod_q;

endmodule

// File: tb/tb_radix16_booth_mult.sv
// Randomised self-checking bench: behavioural selector plus a*b reference and latency model.
module tb_radix16_booth_mult;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sel_dig;

  radix16_booth_mult_if bus ();

  radix16_booth_mult dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Booth digit i of a 33-bit {b,0} vector: -8*w4 + 4*w3 + 2*w2 + w1 + w0.
  function automatic int booth_digit(input logic [32:0] sb, input int i);
    logic [4:0] w;
    w = 5'(sb >> (4 * i));
    return (w[3] ? 4 : 0) + (w[2] ? 2 : 0) + (w[1] ? 1 : 0) + (w[0] ? 1 : 0) - (w[4] ? 8 : 0);
  endfunction

  function automatic int exp_latency(input int bv);
`ifdef RADIX16_EARLY_TERM_EN
    int last = 0;
    for (int i = 0; i < 8; i++) begin
      if (booth_digit({bv, 1'b0}, i) != 0) last = i;
    end
    return 2 + last;
`else
    return 9 + (bv & 0);
`endif
  endfunction

  // External radix selector
  always_comb begin
    sel_dig      = (bus.sel_count < 4'd8) ? booth_digit(bus.sel_b, int'(bus.sel_count)) : 0;
    bus.sel_sign = (sel_dig < 0);
    bus.sel_mag  = (sel_dig < 0) ? 4'(-sel_dig) : 4'(sel_dig);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one multiply; optionally pulse a stray start at cycle inject_cyc.
  task automatic run_op(input int av, input int bv, input int inject_cyc);
    longint exp_p;
    int     exp_lat;
    int     cyc;
    logic   seen;
    exp_p   = longint'(av) * longint'(bv);
    exp_lat = exp_latency(bv);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (cyc == 1) begin
        check_eq("busy_run", 64'(bus.busy), 64'd1);
        check_eq("sel_b", 64'(bus.sel_b), 64'({bv, 1'b0}));
        if (exp_lat > 2) check_eq("sel_count0", 64'(bus.sel_count), 64'd0);
      end
      if (bus.done) seen = 1'b1;
      else if (cyc == inject_cyc) begin
        bus.start = 1'b1;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check_eq("latency", 64'(cyc), 64'(exp_lat));
      check_eq("product", bus.product, exp_p);
      check_eq("busy_done", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check_eq("done_pulse", 64'(bus.done), 64'd0);
      check_eq("product_hold", bus.product, exp_p);
      check_eq("sel_count_idle", 64'(bus.sel_count), 64'd8);
    end
  endtask

  initial begin
    logic seen_done;
    int   av, bv;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_product", bus.product, 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_sel_count", 64'(bus.sel_count), 64'd8);
    check_eq("rst_sel_b", 64'(bus.sel_b), 64'd0);

    run_op(3, 5, 0);
    run_op(-7, 123456, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 0);
    run_op(-1, -1, 4);
    run_op(5, 3, 0);
    run_op(5, -1, 0);
    run_op(5, 32'h1000_0000, 0);
    run_op(32'h7fff_ffff, 32'h8000_0000, 0);
    run_op(123, 0, 0);

    // Abort mid-operation with reset
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 3;
    bus.b     = 5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      if (c == 5) reset = 1'b1;
      if (c == 6) reset = 1'b0;
    end
    check_eq("rst_mid_no_done", 64'(seen_done), 64'd0);
    check_eq("rst_mid_product", bus.product, 64'd0);
    check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_mid_sel_count", 64'(bus.sel_count), 64'd8);
    run_op(3, 5, 0);

    for (int n = 0; n < 40; n++) begin
      av = $urandom;
      case (n % 4)
        0:       bv = int'($urandom_range(0, 255)) - 128;
        1:       bv = int'($urandom_range(0, 65535)) - 32768;
        default: bv = $urandom;
      endcase
      run_op(av, bv, (n % 5 == 0) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
